// File: rtl/object_pingpong_buffer.sv
// -----------------------------------------------------------------------------
// object_pingpong_buffer
//
// Double-banked store for per-frame object records. The producer fills the
// write bank while the consumer drains the read bank. A next_frame pulse swaps
// the two banks and freezes the finished frame's record count and overflow
// status for the consumer.
//
// Ports
//   clock        : clock
//   reset        : asynchronous, active-high reset
//   next_frame   : frame boundary pulse, swaps banks
//   wr_valid     : write request
//   wr_data      : record to write
//   wr_ready     : write bank not full
//   rd_valid     : rd_data holds an unread record of the read bank
//   rd_data      : record at the read pointer of the read bank
//   rd_ready     : consumer accepts rd_data
//   rd_restart   : rewind the read pointer to entry 0
//   wr_count     : records accepted into the write bank this frame
//   rd_count     : records held in the read bank (frozen at the swap)
//   rd_done      : every record of the read bank has been consumed
//   overflow     : sticky, a write was dropped this frame
//   rd_overflow  : the frame now in the read bank overflowed
// -----------------------------------------------------------------------------
module object_pingpong_buffer #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 50
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             next_frame,
    input  logic                             wr_valid,
    input  logic [DATA_W-1:0]                wr_data,
    output logic                             wr_ready,
    output logic                             rd_valid,
    output logic [DATA_W-1:0]                rd_data,
    input  logic                             rd_ready,
    input  logic                             rd_restart,
    output logic [$clog2(DEPTH+1)-1:0]       wr_count,
    output logic [$clog2(DEPTH+1)-1:0]       rd_count,
    output logic                             rd_done,
    output logic                             overflow,
    output logic                             rd_overflow
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Storage: no reset, contents are only meaningful below the counts.
    logic [DATA_W-1:0] bank_mem [0:1][0:DEPTH-1];

    logic             wsel_q,        wsel_d;
    logic [CNT_W-1:0] wr_count_q,    wr_count_d;
    logic [CNT_W-1:0] rd_count_q,    rd_count_d;
    logic [CNT_W-1:0] rd_ptr_q,      rd_ptr_d;
    logic             overflow_q,    overflow_d;
    logic             rd_overflow_q, rd_overflow_d;

    logic             wr_acc;
    logic             wr_drop;
    logic             rd_xfer;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    // Handshake and addressing, all from registered state
    always_comb begin
        wr_ready = (wr_count_q != DEPTH_C);
        rd_valid = (rd_ptr_q < rd_count_q);
        rd_done  = !rd_valid;
        wr_acc   = wr_valid && wr_ready;
        wr_drop  = wr_valid && !wr_ready;
        rd_xfer  = rd_valid && rd_ready;
        // Pointers can legally sit at DEPTH; keep the array index in range.
        wr_idx   = (wr_count_q < DEPTH_C) ? wr_count_q[AW-1:0] : '0;
        rd_idx   = (rd_ptr_q   < DEPTH_C) ? rd_ptr_q[AW-1:0]   : '0;
    end

    assign rd_data     = bank_mem[~wsel_q][rd_idx];
    assign wr_count    = wr_count_q;
    assign rd_count    = rd_count_q;
    assign overflow    = overflow_q;
    assign rd_overflow = rd_overflow_q;

    // Next-state: next_frame > rd_restart > read transfer
    always_comb begin
        wsel_d        = wsel_q;
        wr_count_d    = wr_count_q;
        rd_count_d    = rd_count_q;
        rd_ptr_d      = rd_ptr_q;
        overflow_d    = overflow_q;
        rd_overflow_d = rd_overflow_q;

        if (next_frame) begin
            // A write in the swap cycle still lands in the finished frame.
            wsel_d        = ~wsel_q;
            rd_count_d    = wr_count_q + CNT_W'(wr_acc);
            rd_overflow_d = overflow_q | wr_drop;
            wr_count_d    = '0;
            overflow_d    = 1'b0;
            rd_ptr_d      = '0;
        end else begin
            if (wr_acc) begin
                wr_count_d = wr_count_q + CNT_W'(1);
            end
            if (wr_drop) begin
                overflow_d = 1'b1;
            end
            if (rd_restart) begin
                rd_ptr_d = '0;
            end else if (rd_xfer) begin
                rd_ptr_d = rd_ptr_q + CNT_W'(1);
            end
        end
    end

    // State registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wsel_q        <= 1'b0;
            wr_count_q    <= '0;
            rd_count_q    <= '0;
            rd_ptr_q      <= '0;
            overflow_q    <= 1'b0;
            rd_overflow_q <= 1'b0;
        end else begin
            wsel_q        <= wsel_d;
            wr_count_q    <= wr_count_d;
            rd_count_q    <= rd_count_d;
            rd_ptr_q      <= rd_ptr_d;
            overflow_q    <= overflow_d;
            rd_overflow_q <= rd_overflow_d;
        end
    end

    // Record storage write port
    always_ff @(posedge clock) begin
        if (wr_acc) begin
            bank_mem[wsel_q][wr_idx] <= wr_data;
        end
    end

endmodule

// File: tb/tb_object_pingpong_buffer.sv
module tb_object_pingpong_buffer;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clock = 1'b0;
    logic              reset;
    logic              next_frame;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_ready;
    logic              rd_restart;
    logic [CNT_W-1:0]  wr_count;
    logic [CNT_W-1:0]  rd_count;
    logic              rd_done;
    logic              overflow;
    logic              rd_overflow;

    int checks = 0;
    int errors = 0;

    // Reference model: each bank is a list of records, the read side a cursor.
    logic [DATA_W-1:0] m_wbank[$];
    logic [DATA_W-1:0] m_rbank[$];
    int                m_rptr;
    bit                m_ovf;
    bit                m_rovf;

    object_pingpong_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .next_frame  (next_frame),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_ready    (rd_ready),
        .rd_restart  (rd_restart),
        .wr_count    (wr_count),
        .rd_count    (rd_count),
        .rd_done     (rd_done),
        .overflow    (overflow),
        .rd_overflow (rd_overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wbank.delete();
        m_rbank.delete();
        m_rptr = 0;
        m_ovf  = 0;
        m_rovf = 0;
    endtask

    task automatic check_all();
        bit exp_rv;
        exp_rv = (m_rptr < m_rbank.size());
        chk("wr_ready",    32'(wr_ready),    32'(m_wbank.size() != DEPTH));
        chk("rd_valid",    32'(rd_valid),    32'(exp_rv));
        chk("rd_done",     32'(rd_done),     32'(!exp_rv));
        chk("wr_count",    32'(wr_count),    32'(m_wbank.size()));
        chk("rd_count",    32'(rd_count),    32'(m_rbank.size()));
        chk("overflow",    32'(overflow),    32'(m_ovf));
        chk("rd_overflow", 32'(rd_overflow), 32'(m_rovf));
        if (exp_rv) chk("rd_data", 32'(rd_data), 32'(m_rbank[m_rptr]));
    endtask

    task automatic model_step();
        bit acc, drop, xfer;
        acc  = wr_valid && (m_wbank.size() < DEPTH);
        drop = wr_valid && (m_wbank.size() >= DEPTH);
        xfer = rd_ready && (m_rptr < m_rbank.size());
        if (acc) m_wbank.push_back(wr_data);
        if (next_frame) begin
            m_rbank = m_wbank;
            m_wbank.delete();
            m_rovf  = m_ovf | drop;
            m_ovf   = 0;
            m_rptr  = 0;
        end else begin
            if (drop) m_ovf = 1;
            if (rd_restart) m_rptr = 0;
            else if (xfer) m_rptr++;
        end
    endtask

    // One clock: drive inputs, check outputs at the falling edge, advance model.
    task automatic step(input bit nf, input bit wv, input logic [DATA_W-1:0] wd,
                        input bit rr, input bit rs);
        next_frame = nf;
        wr_valid   = wv;
        wr_data    = wd;
        rd_ready   = rr;
        rd_restart = rs;
        @(negedge clock);
        check_all();
        model_step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [DATA_W-1:0] first_rec;
        reset      = 1'b1;
        next_frame = 1'b0;
        wr_valid   = 1'b0;
        wr_data    = '0;
        rd_ready   = 1'b0;
        rd_restart = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Reset state
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_done",  32'(rd_done),  32'd1);
        chk("rst_wr_count", 32'(wr_count), 32'd0);
        chk("rst_rd_count", 32'(rd_count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);

        // Normal frame
        step(0, 1, 8'h11, 0, 0);
        step(0, 1, 8'h22, 0, 0);
        step(0, 1, 8'h33, 0, 0);
        step(1, 0, 8'h00, 0, 0);
        chk("nf_rd_count", 32'(rd_count), 32'd3);
        chk("nf_first",    32'(rd_data),  32'h11);

        // Drain while filling the other bank past full
        step(0, 1, 8'hA0, 1, 0);
        chk("nf_second", 32'(rd_data), 32'h22);
        step(0, 1, 8'hA1, 1, 0);
        chk("nf_third", 32'(rd_data), 32'h33);
        step(0, 1, 8'hA2, 1, 0);
        chk("nf_done", 32'(rd_done), 32'd1);
        step(0, 1, 8'hA3, 1, 0);
        chk("full_wr_ready", 32'(wr_ready), 32'd0);
        step(0, 1, 8'hA4, 1, 0);
        chk("ovf_set", 32'(overflow), 32'd1);
        step(1, 0, 8'h00, 0, 0);
        chk("ovf_rd_count",    32'(rd_count),    32'd4);
        chk("ovf_rd_overflow", 32'(rd_overflow), 32'd1);
        chk("ovf_cleared",     32'(overflow),    32'd0);
        repeat (5) step(0, 0, 8'h00, 1, 0);

        // Write in the swap cycle
        step(0, 1, 8'h53, 0, 0);
        step(0, 1, 8'h54, 0, 0);
        step(1, 1, 8'h55, 0, 0);
        chk("swapw_rd_count", 32'(rd_count), 32'd3);
        chk("swapw_wr_count", 32'(wr_count), 32'd0);

        // Restart and stall; also refill two records for the reset test
        step(0, 1, 8'h61, 1, 0);
        step(0, 1, 8'h62, 1, 0);
        chk("swapw_third", 32'(rd_data), 32'h55);
        step(0, 0, 8'h00, 1, 1);
        chk("restart_data", 32'(rd_data), 32'h53);
        first_rec = rd_data;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 8'h00, 0, 0);
            chk("stall_data",  32'(rd_data),  32'(first_rec));
            chk("stall_valid", 32'(rd_valid), 32'd1);
        end

        // Asynchronous reset between edges
        chk("pre_rst_rd_count", 32'(rd_count), 32'd3);
        chk("pre_rst_wr_count", 32'(wr_count), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("arst_wr_count", 32'(wr_count), 32'd0);
        chk("arst_rd_count", 32'(rd_count), 32'd0);
        chk("arst_rd_valid", 32'(rd_valid), 32'd0);
        chk("arst_wr_ready", 32'(wr_ready), 32'd1);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check_all();

        // Back-to-back swaps leave an empty read bank
        step(0, 1, 8'h71, 0, 0);
        step(1, 0, 8'h00, 0, 0);
        step(1, 0, 8'h00, 0, 0);
        chk("b2b_rd_count", 32'(rd_count), 32'd0);
        chk("b2b_rd_done",  32'(rd_done),  32'd1);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) != 0),
                 8'($urandom),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 15) == 0));
        end
        step(0, 0, 8'h00, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
